// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the queued instruction fetch stage.
package fetch_pkg;
    localparam int          XLEN_DEFAULT = 32;
    localparam int          INSTR_BYTES  = 4;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/imem_sync.sv
// Synchronous-read instruction ROM; the word is registered on an enabled edge.
module imem_sync #(
  parameter int    IMEM_WORDS = 256,
  parameter int    XLEN       = 32,
  parameter string IMEM_INIT  = ""
) (
  input  logic                          clk,
  input  logic                          en,
  input  logic [$clog2(IMEM_WORDS)-1:0] addr,
  output logic [XLEN-1:0]               rdata
);
  logic [XLEN-1:0] mem [IMEM_WORDS];

  always_ff @(posedge clk) begin
    if (en) rdata <= mem[addr];
  end
endmodule

// File: rtl/instr_fetch_queued.sv
// Fetch stage: PC, one-cycle ROM and a credit-controlled prefetch queue feeding decode.
module instr_fetch_queued
    import fetch_pkg::*;
#(
    parameter int               XLEN        = XLEN_DEFAULT,
    parameter int               IMEM_WORDS  = 256,
    parameter int               QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0]  RESET_PC    = '0,
    parameter string            IMEM_INIT   = ""
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_branch,
    input  logic            pc_source,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_instruction,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_next
);
    localparam int              AW         = $clog2(IMEM_WORDS);
    localparam int              PW         = ptr_w(QUEUE_DEPTH);
    localparam logic [PW+1:0]   DEPTH_L    = (PW+2)'(QUEUE_DEPTH);
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] pc_p1;
    logic            vld_p1;
    logic [XLEN-1:0] imem_rdata;
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic [PW:0]     count;
    logic [PW+1:0]   occupancy;
    logic            issue;
    logic            push;
    logic            pop;
    logic            head_vld;
    logic [XLEN-1:0] q_instr [QUEUE_DEPTH];
    logic [XLEN-1:0] q_pc    [QUEUE_DEPTH];

    // Credit counts the in-flight fetch so a response always has a free slot to land in.
    assign count     = wr_ptr - rd_ptr;
    assign occupancy = {1'b0, count} + {{(PW+1){1'b0}}, vld_p1};
    assign issue     = !pc_source && (occupancy < DEPTH_L);
    assign push      = vld_p1 && !pc_source;
    assign head_vld  = (count != '0);
    assign pop       = head_vld && out_ready && !pc_source;

    assign out_valid       = head_vld;
    assign out_instruction = head_vld ? q_instr[rd_ptr[PW-1:0]] : '0;
    assign out_pc          = head_vld ? q_pc[rd_ptr[PW-1:0]] : '0;
    assign out_pc_next     = head_vld ? q_pc[rd_ptr[PW-1:0]] + STEP : '0;

    // p0 -> p1: issue to the ROM, which returns the word one edge later
    imem_sync #(
        .IMEM_WORDS (IMEM_WORDS),
        .XLEN       (XLEN),
        .IMEM_INIT  (IMEM_INIT)
    ) u_imem (
        .clk   (clk),
        .en    (issue),
        .addr  (pc_p0[AW+1:2]),
        .rdata (imem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_p0  <= RESET_PC;
            vld_p1 <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (pc_source) begin
            pc_p0  <= pc_branch & ALIGN_MASK;
            vld_p1 <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (issue) pc_p0 <= pc_p0 + STEP;
            vld_p1 <= issue;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // p1 -> queue: tag travels with the ROM word into the head storage
    always_ff @(posedge clk) begin
        if (issue) pc_p1 <= pc_p0;
        if (push) begin
            q_instr[wr_ptr[PW-1:0]] <= imem_rdata;
            q_pc[wr_ptr[PW-1:0]]    <= pc_p1;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queued.sv
// Randomised bench for instr_fetch_queued with a queue-based reference model.
module tb_instr_fetch_queued;
    localparam int DEPTH = 4;
    localparam int WORDS = 256;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_branch = '0;
    logic        pc_source = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [31:0] out_instruction, out_pc, out_pc_next;

    logic        w_valid;
    logic [31:0] w_instruction, w_pc, w_pc_next;
    logic [31:0] w_branch = '0;
    logic        w_source = 1'b0;
    logic        w_ready = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mem_m [WORDS];
    ent_t        q[$];
    logic [31:0] pend[$];
    logic [31:0] m_pc = '0;

    always #5 clk = ~clk;

    instr_fetch_queued #(.XLEN(32), .IMEM_WORDS(WORDS), .QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .pc_branch(pc_branch), .pc_source(pc_source),
        .out_ready(out_ready), .out_valid(out_valid), .out_instruction(out_instruction),
        .out_pc(out_pc), .out_pc_next(out_pc_next)
    );

    instr_fetch_queued #(.XLEN(32), .IMEM_WORDS(WORDS), .QUEUE_DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .pc_branch(w_branch), .pc_source(w_source),
        .out_ready(w_ready), .out_valid(w_valid), .out_instruction(w_instruction),
        .out_pc(w_pc), .out_pc_next(w_pc_next)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: queue of fetched words plus at most one outstanding request.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            pend.delete();
            m_pc = 32'h0;
        end else if (pc_source) begin
            q.delete();
            pend.delete();
            m_pc = pc_branch & 32'hFFFF_FFFC;
        end else begin
            bit can_issue;
            logic [31:0] ppc;
            can_issue = (q.size() + pend.size()) < DEPTH;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (pend.size() != 0) begin
                ppc = pend[0];
                q.push_back('{mem_m[ppc[9:2]], ppc});
                pend.delete();
            end
            if (can_issue) begin
                pend.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            check("instr", out_instruction, q[0].instr);
            check("pc", out_pc, q[0].pc);
            check("pc_next", out_pc_next, q[0].pc + 32'd4);
        end else begin
            check("instr_empty", out_instruction, 32'h0);
            check("pc_empty", out_pc, 32'h0);
            check("pc_next_empty", out_pc_next, 32'h0);
        end
    end

    initial begin
        for (int i = 0; i < WORDS; i++) mem_m[i] = $urandom;
        mem_m[0] = 32'd11; mem_m[1] = 32'd22; mem_m[2] = 32'd33; mem_m[3] = 32'd44;
        for (int i = 0; i < WORDS; i++) dut.u_imem.mem[i] = mem_m[i];
        dut_wrap.u_imem.mem[255] = 32'hDEAD_0255;
        dut_wrap.u_imem.mem[0]   = 32'hBEEF_0000;

        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_instr", out_instruction, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_pc_next", out_pc_next, 32'h0);
        reset = 1'b1;

        @(negedge clk);
        check("start_edge1_valid", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        check("start_i0", out_instruction, 32'd11);
        check("start_pc0", out_pc, 32'h0);
        check("start_nx0", out_pc_next, 32'h4);
        check("wrap_pc0", w_pc, 32'hFFFF_FFFC);
        check("wrap_nx0", w_pc_next, 32'h0);
        check("wrap_i0", w_instruction, 32'hDEAD_0255);
        @(negedge clk);
        check("start_i1", out_instruction, 32'd22);
        check("start_pc1", out_pc, 32'h4);
        check("wrap_pc1", w_pc, 32'h0);
        check("wrap_i1", w_instruction, 32'hBEEF_0000);
        check("wrap_nx1", w_pc_next, 32'h4);
        @(negedge clk);
        check("start_i2", out_instruction, 32'd33);
        check("start_pc2", out_pc, 32'h8);
        @(negedge clk);
        check("start_i3", out_instruction, 32'd44);
        check("start_pc3", out_pc, 32'hC);
        check("start_nx3", out_pc_next, 32'h10);

        // Stall with an empty queue restart at 0
        out_ready = 1'b0; pc_source = 1'b1; pc_branch = 32'h0;
        @(negedge clk);
        pc_source = 1'b0;
        repeat (10) @(negedge clk);
        check("stall_valid", {31'b0, out_valid}, 32'h1);
        check("stall_head", out_instruction, 32'd11);
        out_ready = 1'b1;
        @(negedge clk); check("drain_22", out_instruction, 32'd22);
        @(negedge clk); check("drain_33", out_instruction, 32'd33);
        @(negedge clk); check("drain_44", out_instruction, 32'd44);
        @(negedge clk);
        check("resume_pc", out_pc, 32'h10);
        check("resume_instr", out_instruction, mem_m[4]);

        // Redirect while full
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        pc_source = 1'b1; pc_branch = 32'h40;
        @(negedge clk);
        check("redir_flush", {31'b0, out_valid}, 32'h0);
        pc_source = 1'b0;
        @(negedge clk);
        check("redir_e1", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        check("redir_e2", {31'b0, out_valid}, 32'h1);
        check("redir_pc", out_pc, 32'h40);
        check("redir_instr", out_instruction, mem_m[16]);

        // Misaligned redirect with a pop requested in the same cycle
        out_ready = 1'b1; pc_source = 1'b1; pc_branch = 32'h43;
        @(negedge clk);
        check("mis_flush", {31'b0, out_valid}, 32'h0);
        pc_source = 1'b0;
        repeat (2) @(negedge clk);
        check("mis_pc", out_pc, 32'h40);
        check("mis_valid", {31'b0, out_valid}, 32'h1);

        for (int k = 0; k < 3000; k++) begin
            out_ready = ($urandom % 4) != 0;
            pc_source = ($urandom % 20) == 0;
            pc_branch = $urandom;
            @(negedge clk);
        end
        pc_source = 1'b0;

        // Reset mid-stream with three queued entries
        out_ready = 1'b0; pc_source = 1'b1; pc_branch = 32'h0;
        @(negedge clk);
        pc_source = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_valid", {31'b0, out_valid}, 32'h1);
        check("pre_rst_head", out_instruction, 32'd11);
        #2 reset = 1'b0;
        #1;
        check("async_valid", {31'b0, out_valid}, 32'h0);
        check("async_instr", out_instruction, 32'h0);
        check("async_pc", out_pc, 32'h0);
        check("async_pc_next", out_pc_next, 32'h0);
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("restart_instr", out_instruction, 32'd11);
        check("restart_pc", out_pc, 32'h0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
